// File: rtl/mtx_ctrl_tag_seq.sv
// Tag transmit sequencer.
// Each hop is a LOC_SYNCH interval, an optional guard gap, then a transmit
// window that ends on a hop_ready strobe. A fixed number of hops is spent on
// each channel, the channels are visited in order, and frame_done marks the
// wrap from the last channel back to channel 0.
//
// Handshake: hop_ready is a one-cycle strobe with no back-pressure. It is
// consumed only in HOP_TX and ignored in every other state. trig_in arrives
// already synchronised; only its rising edge (low->high between consecutive
// clocks) starts a frame, and only while the FSM is in WAIT_TRIG.
module mtx_ctrl_tag_seq #(
    parameter int DATA_WIDTH     = 16,
    parameter int CNT_WIDTH      = 24,
    parameter int NUM_CH         = 4,
    parameter int CH_WIDTH       = 2,
    parameter int NHOP_WIDTH     = 8,
    parameter int HOPS_PER_CH    = 64,
    parameter int SYNC_LEN       = 16384,
    parameter int BLANK_LEN      = 4096,
    parameter int GUARD_LEN      = 256,
    parameter int TRIG_MODE      = 0,
    parameter int GPIO_REG_WIDTH = 12,
    parameter logic [GPIO_REG_WIDTH-1:0] SYNC_OUT_MASK = 12'h001,
    parameter logic [GPIO_REG_WIDTH-1:0] TX_OUT_MASK   = 12'h010
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           trig_in,
    input  logic                           hop_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_idata,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_qdata,
    output logic [DATA_WIDTH-1:0]          itx,
    output logic [DATA_WIDTH-1:0]          qtx,
    output logic                           gen_srst,
    output logic [CH_WIDTH-1:0]            ch_sel,
    output logic [NHOP_WIDTH-1:0]          hop_cnt,
    output logic [GPIO_REG_WIDTH-1:0]      gpio_out,
    output logic [2:0]                     state,
    output logic [CNT_WIDTH-1:0]           sync_count,
    output logic                           frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_LOC_SYNCH = 3'd2,
        ST_GUARD     = 3'd3,
        ST_HOP_TX    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  SYNC_LOAD  = CNT_WIDTH'(SYNC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  GUARD_LOAD = CNT_WIDTH'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);
    localparam logic [CNT_WIDTH-1:0]  BLANK_LIM  = CNT_WIDTH'(BLANK_LEN);
    localparam logic [NHOP_WIDTH-1:0] HOP_LAST   = NHOP_WIDTH'(HOPS_PER_CH - 1);
    localparam logic [CH_WIDTH-1:0]   CH_LAST    = CH_WIDTH'(NUM_CH - 1);
    // After a frame wraps, either rearm on the trigger or start the next sync at once.
    localparam state_t FRAME_START = (TRIG_MODE == 1) ? ST_WAIT_TRIG : ST_LOC_SYNCH;

    state_t                  st;
    logic                    trig_prev;
    logic                    trig_edge;
    logic [DATA_WIDTH-1:0]   sel_i;
    logic [DATA_WIDTH-1:0]   sel_q;

    assign state     = st;
    assign trig_edge = trig_in & ~trig_prev;

    // Generator is held in reset while idle, waiting, blanked, or guarding.
    always_comb begin
        gen_srst = 1'b0;
        case (st)
            ST_IDLE, ST_WAIT_TRIG, ST_GUARD: gen_srst = 1'b1;
            ST_LOC_SYNCH: gen_srst = (sync_count < BLANK_LIM);
            default: gen_srst = 1'b0;
        endcase
    end

    // GPIO image flags the sync interval and the transmit window.
    always_comb begin
        gpio_out = '0;
        if (st == ST_LOC_SYNCH)
            gpio_out = SYNC_OUT_MASK;
        else if (st == ST_HOP_TX)
            gpio_out = TX_OUT_MASK;
    end

    // Select the active channel's IQ slice.
    always_comb begin
        sel_i = '0;
        sel_q = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_WIDTH'(k)) begin
                sel_i = in_idata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_q = in_qdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered IQ output, forced to zero whenever the generator is in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            itx <= '0;
            qtx <= '0;
        end else if (gen_srst) begin
            itx <= '0;
            qtx <= '0;
        end else begin
            itx <= sel_i;
            qtx <= sel_q;
        end
    end

    // Sequencer FSM with its sync/guard down-counter, hop and channel counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            sync_count <= SYNC_LOAD;
            hop_cnt    <= '0;
            ch_sel     <= '0;
            frame_done <= 1'b0;
            trig_prev  <= 1'b0;
        end else begin
            trig_prev  <= trig_in;
            frame_done <= 1'b0;
            if (!enable) begin
                st         <= ST_IDLE;
                sync_count <= SYNC_LOAD;
                hop_cnt    <= '0;
                ch_sel     <= '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        st         <= (TRIG_MODE == 1) ? ST_WAIT_TRIG : ST_LOC_SYNCH;
                        sync_count <= SYNC_LOAD;
                    end
                    ST_WAIT_TRIG: begin
                        if (trig_edge)
                            st <= ST_LOC_SYNCH;
                    end
                    ST_LOC_SYNCH: begin
                        if (sync_count == '0) begin
                            if (GUARD_LEN == 0) begin
                                st <= ST_HOP_TX;
                            end else begin
                                st         <= ST_GUARD;
                                sync_count <= GUARD_LOAD;
                            end
                        end else begin
                            sync_count <= sync_count - CNT_WIDTH'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (sync_count == '0)
                            st <= ST_HOP_TX;
                        else
                            sync_count <= sync_count - CNT_WIDTH'(1);
                    end
                    ST_HOP_TX: begin
                        if (hop_ready) begin
                            sync_count <= SYNC_LOAD;
                            if (hop_cnt != HOP_LAST) begin
                                hop_cnt <= hop_cnt + NHOP_WIDTH'(1);
                                st      <= ST_LOC_SYNCH;
                            end else begin
                                hop_cnt <= '0;
                                if (ch_sel == CH_LAST) begin
                                    ch_sel     <= '0;
                                    frame_done <= 1'b1;
                                    st         <= FRAME_START;
                                end else begin
                                    ch_sel <= ch_sel + CH_WIDTH'(1);
                                    st     <= ST_LOC_SYNCH;
                                end
                            end
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
